// File: rtl/palindrome_pkg.sv
// Shared definitions for the bit-palindrome checking stage.
//   PAL_DEFAULT_WIDTH : default word width of the detector
//   PAL_MAX_WIDTH     : widest word the shared helper handles
//   pal_mirror_xor()  : mismatch vector of mirrored bit pairs for any width up to PAL_MAX_WIDTH
package palindrome_pkg;

  localparam int unsigned PAL_DEFAULT_WIDTH = 8;
  localparam int unsigned PAL_MAX_WIDTH     = 64;

  // Bit i of the result is word[i] ^ word[width-1-i] for i < width/2; upper bits are zero.
  // The word is right-aligned: bits at or above width are ignored.
  function automatic logic [PAL_MAX_WIDTH/2-1:0] pal_mirror_xor(
    input logic [PAL_MAX_WIDTH-1:0] word,
    input int unsigned              width
  );
    logic [PAL_MAX_WIDTH/2-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PAL_MAX_WIDTH / 2; i++) begin
      if (i < width / 2) begin
        m[i] = word[i] ^ word[6'(width - 1 - i)];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/palindrome_bit_reverse.sv
// bit_reverse stage of the palindrome detector: purely combinational bit-order reversal.
//   din  [WIDTH-1:0] : input word
//   dout [WIDTH-1:0] : dout[i] = din[WIDTH-1-i]
module palindrome_bit_reverse #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      dout[i] = din[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/palindrome.sv
// Registered bit-palindrome detector. Each accepted word is compared with its bit-reversed
// image; results appear one clock after the accepting edge, one word per clock.
//   clk           : rising-edge clock
//   rst           : synchronous reset, active-high, wins over in_valid
//   data          : word under test
//   in_valid      : data is sampled when high at a clk edge
//   is_palindrome : 1 = last accepted word is a bit palindrome
//   out_valid     : outputs carry a fresh result this cycle
//   mismatch_mask : bit i = data[i] ^ data[WIDTH-1-i] of the last accepted word
module palindrome
  import palindrome_pkg::*;
#(
  parameter int unsigned WIDTH = PAL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data,
  input  logic               in_valid,
  output logic               is_palindrome,
  output logic               out_valid,
  output logic [WIDTH/2-1:0] mismatch_mask
);

  logic [WIDTH-1:0]   data_rev;
  logic [WIDTH/2-1:0] mask_d;
  logic               pal_d;

  palindrome_bit_reverse #(
    .WIDTH (WIDTH)
  ) u_bit_reverse (
    .din  (data),
    .dout (data_rev)
  );

  // rev[i] is data[WIDTH-1-i], so only the lower half carries distinct pairs; an odd centre
  // bit lands on itself and can never mismatch.
  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < WIDTH / 2; i++) begin
      mask_d[i] = data[i] ^ data_rev[i];
    end
    // Full-word compare is equivalent to ~|mask_d and keeps every reversed bit in use.
    pal_d = (data == data_rev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_palindrome <= 1'b0;
      out_valid     <= 1'b0;
      mismatch_mask <= '0;
    end else if (in_valid) begin
      is_palindrome <= pal_d;
      out_valid     <= 1'b1;
      mismatch_mask <= mask_d;
    end else begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_palindrome.sv
// Directed and random self-checking bench for palindrome (WIDTH=8 and WIDTH=5 instances).
module tb_palindrome;

  logic       clk;
  logic       rst;
  logic [7:0] data8;
  logic       v8;
  logic       pal8;
  logic       ov8;
  logic [3:0] mask8;
  logic [4:0] data5;
  logic       v5;
  logic       pal5;
  logic       ov5;
  logic [1:0] mask5;

  int tests;
  int fails;

  palindrome #(
    .WIDTH (8)
  ) dut8 (
    .clk           (clk),
    .rst           (rst),
    .data          (data8),
    .in_valid      (v8),
    .is_palindrome (pal8),
    .out_valid     (ov8),
    .mismatch_mask (mask8)
  );

  palindrome #(
    .WIDTH (5)
  ) dut5 (
    .clk           (clk),
    .rst           (rst),
    .data          (data5),
    .in_valid      (v5),
    .is_palindrome (pal5),
    .out_valid     (ov5),
    .mismatch_mask (mask5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle: inputs were set before, outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    v8    = 1'b1;
    data8 = 8'hFF;
    v5    = 1'b1;
    data5 = 5'h1F;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if ({ov8, pal8, mask8} !== 6'b0) begin
        fails++;
        $display("FAIL reset8 cycle %0d: got ov/pal/mask=%b required 000000", c, {ov8, pal8, mask8});
      end
      tests++;
      if ({ov5, pal5, mask5} !== 4'b0) begin
        fails++;
        $display("FAIL reset5 cycle %0d: got ov/pal/mask=%b required 0000", c, {ov5, pal5, mask5});
      end
    end
    rst   = 1'b0;
    v5    = 1'b0;
    data8 = 8'b1000_0001;
    tick();
    tests++;
    if ({ov8, pal8, mask8} !== 6'b11_0000) begin
      fails++;
      $display("FAIL reset_release: got ov/pal/mask=%b required 110000", {ov8, pal8, mask8});
    end
    v8 = 1'b0;
    tick();
  endtask

  task automatic test_palindromes();
    logic [7:0] words [5];
    words = '{8'b1000_0001, 8'b1100_0011, 8'b1111_1111, 8'b1010_0101, 8'b1001_1001};
    v8 = 1'b1;
    foreach (words[k]) begin
      data8 = words[k];
      tick();
      tests++;
      if ({ov8, pal8, mask8} !== 6'b11_0000) begin
        fails++;
        $display("FAIL palindrome %b: got ov/pal/mask=%b required 110000", words[k],
                 {ov8, pal8, mask8});
      end
    end
    v8 = 1'b0;
    tick();
    tests++;
    if (ov8 !== 1'b0) begin
      fails++;
      $display("FAIL valid_drop: got out_valid=%b required 0", ov8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic [5:0] exp   [4];
    words = '{8'b1001_1100, 8'b0000_0001, 8'b0000_0000, 8'b0110_0000};
    exp   = '{6'b10_0101,   6'b10_0001,   6'b11_0000,   6'b10_0110};
    v8 = 1'b1;
    foreach (words[k]) begin
      data8 = words[k];
      tick();
      tests++;
      if ({ov8, pal8, mask8} !== exp[k]) begin
        fails++;
        $display("FAIL b2b %b: got ov/pal/mask=%b required %b", words[k], {ov8, pal8, mask8},
                 exp[k]);
      end
    end
    v8 = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    v8    = 1'b1;
    data8 = 8'b1001_1100;
    tick();
    v8    = 1'b0;
    data8 = 8'b1000_0001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) data8 = 8'bxxxx_zzzz;
      tick();
      tests++;
      if ({ov8, pal8, mask8} !== 6'b00_0101) begin
        fails++;
        $display("FAIL hold cycle %0d: got ov/pal/mask=%b required 000101", c, {ov8, pal8, mask8});
      end
    end
    data8 = 8'h00;
  endtask

  task automatic test_odd_width();
    logic [4:0] words [3];
    logic [3:0] exp   [3];
    words = '{5'b10001, 5'b10101, 5'b10010};
    exp   = '{4'b1100,  4'b1100,  4'b1011};
    v5 = 1'b1;
    foreach (words[k]) begin
      data5 = words[k];
      tick();
      tests++;
      if ({ov5, pal5, mask5} !== exp[k]) begin
        fails++;
        $display("FAIL odd5 %b: got ov/pal/mask=%b required %b", words[k], {ov5, pal5, mask5},
                 exp[k]);
      end
    end
    v5 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic       e_ov;
    logic       e_pal;
    logic [3:0] e_mask;
    logic [7:0] rev;
    int         nerr;
    // Model starts from the held state left by the previous test.
    e_ov   = 1'b0;
    e_pal  = pal8;
    e_mask = mask8;
    nerr   = 0;
    for (int n = 0; n < 1000; n++) begin
      rst   = ($urandom_range(0, 31) == 0);
      v8    = ($urandom_range(0, 2) != 0);
      // Bias toward palindromes so both outcomes are well exercised.
      data8 = 8'($urandom);
      if ($urandom_range(0, 2) == 0) data8[3:0] = {data8[4], data8[5], data8[6], data8[7]};
      for (int i = 0; i < 8; i++) rev[i] = data8[7 - i];
      if (rst) begin
        e_ov = 1'b0; e_pal = 1'b0; e_mask = 4'b0;
      end else if (v8) begin
        e_ov   = 1'b1;
        e_pal  = (data8 == rev);
        for (int i = 0; i < 4; i++) e_mask[i] = (data8[i] != data8[7 - i]);
      end else begin
        e_ov = 1'b0;
      end
      tick();
      tests++;
      if ({ov8, pal8, mask8} !== {e_ov, e_pal, e_mask}) begin
        fails++;
        if (nerr < 10) begin
          $display("FAIL random #%0d data=%b: got ov/pal/mask=%b required %b", n, data8,
                   {ov8, pal8, mask8}, {e_ov, e_pal, e_mask});
        end
        nerr++;
      end
    end
    rst = 1'b0;
    v8  = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    v8    = 1'b0;
    v5    = 1'b0;
    data8 = '0;
    data5 = '0;
    #2;
    test_reset();
    test_palindromes();
    test_back_to_back();
    test_hold();
    test_odd_width();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
